io_bridge_rr: RTL and testbench
===============================

Name: io_bridge_rr

Overview:
- Parametrised successor to the single-master I/O bridge.
- Registers one I/O access at a time from NSLV CPU-side slave ports onto a single master I/O bus, with round-robin arbitration.
- Filters each request against an I/O address window, with one excluded sub-window. Optional posted writes and a bus timeout that returns an error.
- Sits between the CPU/DMA masters and the low-speed peripheral bus. Adds one registered stage in each direction.

Parameters:
- NSLV, 4: number of slave (requester) ports, 1..8.
- DW, 32: data width; byte-select width is DW/8.
- AW, 32: address width.
- IO_BASE, 32'hFD000000: I/O window base.
- IO_MASK, 32'hFF000000: I/O window compare mask.
- EX_BASE, 32'hFD200000: excluded sub-window base, served by another path.
- EX_MASK, 32'hFFF00000: excluded sub-window mask.
- TMO, 255: master-ack timeout in clocks; 0 disables the timeout.
- POSTED_WR, 0: 1 = acknowledge writes to the requester before the master ack arrives.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- io_gate_en_i  in  1  when 0, no new grant is issued
- s_cyc_i  in  NSLV  per-port cycle
- s_stb_i  in  NSLV  per-port strobe
- s_we_i  in  NSLV  per-port write enable
- s_sel_i  in  NSLV x DW/8  byte selects
- s_adr_i  in  NSLV x AW  addresses
- s_dat_i  in  NSLV x DW  write data
- s_ack_o  out  NSLV  acknowledge
- s_err_o  out  NSLV  timeout error
- s_dat_o  out  NSLV x DW  read data
- m_cyc_o  out  1  master cycle
- m_stb_o  out  1  master strobe
- m_we_o  out  1  master write enable
- m_sel_o  out  DW/8  master byte selects
- m_adr_o  out  AW  master address
- m_dat_o  out  DW  master write data
- m_ack_i  in  1  master acknowledge
- m_dat_i  in  DW  master read data

Behaviour:
- Reset: all m_* outputs 0. s_ack_o, s_err_o and s_dat_o are 0. state=IDLE, grant=0, rr_ptr=0, tmo_cnt=0.
- Hit for port i: s_cyc_i[i] & s_stb_i[i] & ((adr&IO_MASK)==IO_BASE) & ((adr&EX_MASK)!=EX_BASE). A non-hit request is ignored and never acknowledged.
- s_ack_o[i] = ack_r & s_stb_i[i] & (grant==i). s_err_o[i] = err_r & s_stb_i[i] & (grant==i). Both are combinational from registered flags, so they drop in the same cycle the strobe drops.
- s_dat_o[i] is registered: it holds the read data while ack is asserted to grant i, and is 0 otherwise.
- IDLE:
  - Arbitration runs only if io_gate_en_i=1 and m_ack_i=0.
  - Pick the first hitting port searching from rr_ptr upward, with wrap-around at NSLV-1 to 0.
  - Latch grant and drive m_cyc/m_stb/m_we/m_sel/m_adr/m_dat from that port on the next edge.
  - rr_ptr <= grant+1 (mod NSLV). Clear tmo_cnt.
  - If POSTED_WR=1 and the access is a write: set ack_r and go to WR_POST. Otherwise go to WAIT_ACK.
  - Request-to-master latency is 1 clock.
- WAIT_ACK:
  - On m_ack_i: clear the master bus, set ack_r, capture m_dat_i into s_dat_o[grant], go to WAIT_NACK. Master-ack-to-slave-ack latency is 1 clock.
  - Else if s_cyc_i[grant]=0 (abort): clear the bus, go to IDLE, no ack.
  - Else if TMO!=0 and tmo_cnt==TMO-1: clear the bus, set err_r, go to WAIT_NACK.
  - Otherwise tmo_cnt increments; it saturates and does not wrap.
- WAIT_NACK: when s_stb_i[grant]=0 or s_cyc_i[grant]=0, clear ack_r, err_r and s_dat_o[grant], then go to IDLE. A new grant is possible 1 clock later.
- WR_POST: the master side and the requester side complete independently.
  - On m_ack_i: clear the bus.
  - When the requester strobe drops: clear ack_r.
  - Go to IDLE only when both are done.
  - Timeout in WR_POST: clear the bus silently; no error is reported.
- Simultaneous events:
  - m_ack_i and timeout expiry in the same cycle: the ack wins.
  - m_ack_i and requester abort in the same cycle: the ack wins. ack_r is set and then clears in WAIT_NACK.
- The master strobe is never reasserted while m_ack_i is high.
- Reset mid-transaction aborts immediately with the reset values above, and no ack is issued.

Decomposition:
- Package io_bridge_pkg holds:
  - the state enum: IDLE, WAIT_ACK, WAIT_NACK, WR_POST;
  - the window-hit function.
- Sub-module rr_arbiter (NSLV param): inputs req vector and ptr; outputs grant index and a valid flag. Purely combinational.

Test Plan:
- Port 1 read of 0xFD010004, master acks after 3 clocks with 0xDEADBEEF -> m_adr_o=0xFD010004 one clock after the request. s_ack_o[1]=1 with s_dat_o[1]=0xDEADBEEF one clock after m_ack_i. Ack drops in the same cycle stb drops.
- Ports 0, 2 and 3 request continuously, each master access acked after 1 clock -> grants go 0,2,3,0,2,... with no port starved and no back-to-back grant while m_ack_i is high.
- Access to 0xFD200000 and to 0xFE000000 -> m_cyc_o stays 0 and no s_ack_o.
- TMO=8, master never acks -> s_err_o[grant]=1 after 8 clocks in WAIT_ACK and m_cyc_o=0. Error clears when stb drops.
- POSTED_WR=1, write of 0x12345678 -> s_ack_o one clock after the request, before m_ack_i. A next request is not granted until m_ack_i is received.
- Assert rst_i while in WAIT_ACK, then give a late m_ack_i -> all outputs are 0 and no spurious s_ack_o.

Source files
------------

// File: rtl/io_bridge_pkg.sv
// Shared types and helpers for the round-robin I/O bridge.
// Holds the FSM state encoding and the address window filter.
package io_bridge_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_ACK  = 2'd1,
    WAIT_NACK = 2'd2,
    WR_POST   = 2'd3
  } state_t;

  // True when adr is inside the I/O window but outside the excluded hole.
  function automatic logic io_hit(
    input logic [63:0] adr,
    input logic [63:0] base,
    input logic [63:0] mask,
    input logic [63:0] ex_base,
    input logic [63:0] ex_mask
  );
    return ((adr & mask) == base) &&
           ((adr & ex_mask) != ex_base);
  endfunction

endpackage

// File: rtl/io_bridge_rr_arb.sv
// Combinational round-robin picker.
// Returns the first requesting index at or after ptr, wrapping.
module rr_arbiter #(
  parameter int NSLV = 4,
  parameter int IW   = (NSLV > 1) ? $clog2(NSLV) : 1
) (
  input  logic [NSLV-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic [IW-1:0]   grant,
  output logic            valid
);

  int j;

  always_comb begin
    valid = 1'b0;
    grant = '0;
    j     = 0;
    for (int k = 0; k < NSLV; k++) begin
      j = int'(ptr) + k;
      if (j >= NSLV) j = j - NSLV;
      if (!valid && req[j]) begin
        valid = 1'b1;
        grant = IW'(j);
      end
    end
  end

endmodule

// File: rtl/io_bridge_rr.sv
// Multi-port I/O bridge: filters requests against the I/O window and
// forwards one access at a time to the master bus, round-robin.
module io_bridge_rr
  import io_bridge_pkg::*;
#(
  parameter int            NSLV      = 4,
  parameter int            DW        = 32,
  parameter int            AW        = 32,
  parameter logic [AW-1:0] IO_BASE   = 32'hFD000000,
  parameter logic [AW-1:0] IO_MASK   = 32'hFF000000,
  parameter logic [AW-1:0] EX_BASE   = 32'hFD200000,
  parameter logic [AW-1:0] EX_MASK   = 32'hFFF00000,
  parameter int            TMO       = 255,
  parameter bit            POSTED_WR = 1'b0
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          io_gate_en_i,
  input  logic [NSLV-1:0]               s_cyc_i,
  input  logic [NSLV-1:0]               s_stb_i,
  input  logic [NSLV-1:0]               s_we_i,
  input  logic [NSLV-1:0][DW/8-1:0]     s_sel_i,
  input  logic [NSLV-1:0][AW-1:0]       s_adr_i,
  input  logic [NSLV-1:0][DW-1:0]       s_dat_i,
  output logic [NSLV-1:0]               s_ack_o,
  output logic [NSLV-1:0]               s_err_o,
  output logic [NSLV-1:0][DW-1:0]       s_dat_o,
  output logic                          m_cyc_o,
  output logic                          m_stb_o,
  output logic                          m_we_o,
  output logic [DW/8-1:0]               m_sel_o,
  output logic [AW-1:0]                 m_adr_o,
  output logic [DW-1:0]                 m_dat_o,
  input  logic                          m_ack_i,
  input  logic [DW-1:0]                 m_dat_i
);

  localparam int SW = DW / 8;
  localparam int IW = (NSLV > 1) ? $clog2(NSLV) : 1;
  localparam int TW = $clog2(TMO + 2);

  state_t                  state_q, state_d;
  logic [IW-1:0]           grant_q, grant_d;
  logic [IW-1:0]           ptr_q, ptr_d;
  logic [TW-1:0]           tmo_q, tmo_d;
  logic                    ack_q, ack_d;
  logic                    err_q, err_d;
  logic                    cyc_q, cyc_d;
  logic                    stb_q, stb_d;
  logic                    we_q, we_d;
  logic [SW-1:0]           sel_q, sel_d;
  logic [AW-1:0]           adr_q, adr_d;
  logic [DW-1:0]           dat_q, dat_d;
  logic [NSLV-1:0][DW-1:0] sdat_q, sdat_d;

  logic [NSLV-1:0] hit;
  logic [IW-1:0]   arb_grant;
  logic            arb_valid;
  logic            g_cyc;
  logic            g_stb;
  logic            tmo_hit;
  logic [TW-1:0]   tmo_inc;

  always_comb begin
    hit = '0;
    for (int i = 0; i < NSLV; i++) begin
      hit[i] = s_cyc_i[i] & s_stb_i[i] &
               io_hit(64'(s_adr_i[i]), 64'(IO_BASE),
                      64'(IO_MASK), 64'(EX_BASE),
                      64'(EX_MASK));
    end
  end

  rr_arbiter #(
    .NSLV (NSLV),
    .IW   (IW)
  ) u_arb (
    .req   (hit),
    .ptr   (ptr_q),
    .grant (arb_grant),
    .valid (arb_valid)
  );

  assign g_cyc   = s_cyc_i[grant_q];
  assign g_stb   = s_stb_i[grant_q];
  assign tmo_hit = (TMO != 0) && (int'(tmo_q) == TMO - 1);
  assign tmo_inc = (tmo_q == '1) ? tmo_q : tmo_q + 1'b1;

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    ptr_d   = ptr_q;
    tmo_d   = tmo_q;
    ack_d   = ack_q;
    err_d   = err_q;
    cyc_d   = cyc_q;
    stb_d   = stb_q;
    we_d    = we_q;
    sel_d   = sel_q;
    adr_d   = adr_q;
    dat_d   = dat_q;
    sdat_d  = sdat_q;
    unique case (state_q)
      IDLE: begin
        if (io_gate_en_i && !m_ack_i && arb_valid) begin
          grant_d = arb_grant;
          cyc_d   = 1'b1;
          stb_d   = 1'b1;
          we_d    = s_we_i[arb_grant];
          sel_d   = s_sel_i[arb_grant];
          adr_d   = s_adr_i[arb_grant];
          dat_d   = s_dat_i[arb_grant];
          ptr_d   = (arb_grant == IW'(NSLV - 1)) ?
                    '0 : arb_grant + 1'b1;
          tmo_d   = '0;
          if (POSTED_WR && s_we_i[arb_grant]) begin
            ack_d   = 1'b1;
            state_d = WR_POST;
          end else begin
            state_d = WAIT_ACK;
          end
        end
      end
      WAIT_ACK: begin
        if (m_ack_i || !g_cyc || tmo_hit) begin
          cyc_d = 1'b0;
          stb_d = 1'b0;
          we_d  = 1'b0;
          sel_d = '0;
          adr_d = '0;
          dat_d = '0;
        end
        if (m_ack_i) begin
          ack_d           = 1'b1;
          sdat_d[grant_q] = m_dat_i;
          state_d         = WAIT_NACK;
        end else if (!g_cyc) begin
          state_d = IDLE;
        end else if (tmo_hit) begin
          err_d   = 1'b1;
          state_d = WAIT_NACK;
        end else begin
          tmo_d = tmo_inc;
        end
      end
      WAIT_NACK: begin
        if (!g_stb || !g_cyc) begin
          ack_d           = 1'b0;
          err_d           = 1'b0;
          sdat_d[grant_q] = '0;
          state_d         = IDLE;
        end
      end
      WR_POST: begin
        // Master and requester sides retire independently.
        if (cyc_q) begin
          if (m_ack_i || tmo_hit) begin
            cyc_d = 1'b0;
            stb_d = 1'b0;
            we_d  = 1'b0;
            sel_d = '0;
            adr_d = '0;
            dat_d = '0;
          end else begin
            tmo_d = tmo_inc;
          end
        end
        if (ack_q && (!g_stb || !g_cyc)) ack_d = 1'b0;
        if (!cyc_d && !ack_d) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      grant_q <= '0;
      ptr_q   <= '0;
      tmo_q   <= '0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      cyc_q   <= 1'b0;
      stb_q   <= 1'b0;
      we_q    <= 1'b0;
      sel_q   <= '0;
      adr_q   <= '0;
      dat_q   <= '0;
      sdat_q  <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
      tmo_q   <= tmo_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      cyc_q   <= cyc_d;
      stb_q   <= stb_d;
      we_q    <= we_d;
      sel_q   <= sel_d;
      adr_q   <= adr_d;
      dat_q   <= dat_d;
      sdat_q  <= sdat_d;
    end
  end

  always_comb begin
    s_ack_o = '0;
    s_err_o = '0;
    for (int i = 0; i < NSLV; i++) begin
      s_ack_o[i] = ack_q & s_stb_i[i] & (grant_q == IW'(i));
      s_err_o[i] = err_q & s_stb_i[i] & (grant_q == IW'(i));
    end
  end

  assign s_dat_o = sdat_q;
  assign m_cyc_o = cyc_q;
  assign m_stb_o = stb_q;
  assign m_we_o  = we_q;
  assign m_sel_o = sel_q;
  assign m_adr_o = adr_q;
  assign m_dat_o = dat_q;

endmodule

// File: tb/tb_io_bridge_rr.sv
// Directed bench for io_bridge_rr (TMO=8, posted writes on).
// Each task drives one scenario and checks against hand values.
module tb_io_bridge_rr;

  logic                 clk_i = 1'b0;
  logic                 rst_i;
  logic                 io_gate_en_i;
  logic [3:0]           s_cyc_i, s_stb_i, s_we_i;
  logic [3:0][3:0]      s_sel_i;
  logic [3:0][31:0]     s_adr_i, s_dat_i;
  logic [3:0]           s_ack_o, s_err_o;
  logic [3:0][31:0]     s_dat_o;
  logic                 m_cyc_o, m_stb_o, m_we_o;
  logic [3:0]           m_sel_o;
  logic [31:0]          m_adr_o, m_dat_o;
  logic                 m_ack_i;
  logic [31:0]          m_dat_i;

  int n_cmp = 0;
  int n_bad = 0;

  io_bridge_rr #(
    .NSLV (4), .DW (32), .AW (32),
    .TMO (8), .POSTED_WR (1'b1)
  ) dut (
    .clk_i (clk_i), .rst_i (rst_i),
    .io_gate_en_i (io_gate_en_i),
    .s_cyc_i (s_cyc_i), .s_stb_i (s_stb_i),
    .s_we_i (s_we_i), .s_sel_i (s_sel_i),
    .s_adr_i (s_adr_i), .s_dat_i (s_dat_i),
    .s_ack_o (s_ack_o), .s_err_o (s_err_o),
    .s_dat_o (s_dat_o),
    .m_cyc_o (m_cyc_o), .m_stb_o (m_stb_o),
    .m_we_o (m_we_o), .m_sel_o (m_sel_o),
    .m_adr_o (m_adr_o), .m_dat_o (m_dat_o),
    .m_ack_i (m_ack_i), .m_dat_i (m_dat_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle_inputs();
    io_gate_en_i = 1'b1;
    s_cyc_i = '0; s_stb_i = '0; s_we_i = '0;
    s_sel_i = '0; s_adr_i = '0; s_dat_i = '0;
    m_ack_i = 1'b0; m_dat_i = '0;
  endtask

  task automatic req(input int p, input logic [31:0] a,
                     input logic we, input logic [31:0] d);
    s_cyc_i[p] = 1'b1; s_stb_i[p] = 1'b1; s_we_i[p] = we;
    s_sel_i[p] = 4'hF; s_adr_i[p] = a; s_dat_i[p] = d;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_i = 1'b1;
    step(); step();
    rst_i = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++;
    if (m_cyc_o !== 1'b0 || m_stb_o !== 1'b0 || m_we_o !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_mbus: cyc/stb/we=%b%b%b want 000", m_cyc_o, m_stb_o, m_we_o);
    end
    n_cmp++;
    if (m_adr_o !== 32'h0 || m_dat_o !== 32'h0 || m_sel_o !== 4'h0) begin
      n_bad++;
      $display("FAIL reset_mdata: adr=%h dat=%h sel=%h want 0", m_adr_o, m_dat_o, m_sel_o);
    end
    n_cmp++;
    if (s_ack_o !== 4'h0 || s_err_o !== 4'h0) begin
      n_bad++;
      $display("FAIL reset_sack: ack=%b err=%b want 0", s_ack_o, s_err_o);
    end
    n_cmp++;
    if (s_dat_o !== 128'h0) begin
      n_bad++;
      $display("FAIL reset_sdat: got %h want 0", s_dat_o);
    end
  endtask

  task automatic test_read();
    req(1, 32'hFD010004, 1'b0, 32'h0);
    step();
    n_cmp++;
    if (m_cyc_o !== 1'b1 || m_adr_o !== 32'hFD010004 || m_we_o !== 1'b0) begin
      n_bad++;
      $display("FAIL read_issue: cyc=%b adr=%h we=%b want 1 fd010004 0", m_cyc_o, m_adr_o, m_we_o);
    end
    step(); step();
    m_ack_i = 1'b1; m_dat_i = 32'hDEADBEEF;
    n_cmp++;
    if (s_ack_o !== 4'h0) begin
      n_bad++;
      $display("FAIL read_early_ack: got %b want 0000", s_ack_o);
    end
    step();
    m_ack_i = 1'b0; m_dat_i = '0;
    n_cmp++;
    if (s_ack_o !== 4'b0010 || s_dat_o[1] !== 32'hDEADBEEF) begin
      n_bad++;
      $display("FAIL read_ack: ack=%b dat=%h want 0010 deadbeef", s_ack_o, s_dat_o[1]);
    end
    n_cmp++;
    if (m_cyc_o !== 1'b0) begin
      n_bad++;
      $display("FAIL read_bus_clear: cyc=%b want 0", m_cyc_o);
    end
    s_stb_i[1] = 1'b0;
    #1;
    n_cmp++;
    if (s_ack_o !== 4'h0) begin
      n_bad++;
      $display("FAIL read_ack_drop: got %b want 0000", s_ack_o);
    end
    s_cyc_i[1] = 1'b0;
    step();
    n_cmp++;
    if (s_dat_o[1] !== 32'h0) begin
      n_bad++;
      $display("FAIL read_dat_clear: got %h want 0", s_dat_o[1]);
    end
  endtask

  task automatic test_round_robin();
    int exp_p[6] = '{0, 2, 3, 0, 2, 3};
    logic [31:0] a;
    do_reset();
    req(0, 32'hFD000000, 1'b0, 0);
    req(2, 32'hFD000200, 1'b0, 0);
    req(3, 32'hFD000300, 1'b0, 0);
    for (int k = 0; k < 6; k++) begin
      step();
      a = 32'hFD000000 | (32'(exp_p[k]) << 8);
      n_cmp++;
      if (m_cyc_o !== 1'b1 || m_adr_o !== a) begin
        n_bad++;
        $display("FAIL rr_grant%0d: cyc=%b adr=%h want 1 %h", k, m_cyc_o, m_adr_o, a);
      end
      m_ack_i = 1'b1;
      step();
      m_ack_i = 1'b0;
      n_cmp++;
      if (s_ack_o !== (4'b1 << exp_p[k]) || m_cyc_o !== 1'b0) begin
        n_bad++;
        $display("FAIL rr_ack%0d: ack=%b cyc=%b want %b 0", k, s_ack_o, m_cyc_o, 4'b1 << exp_p[k]);
      end
      s_stb_i[exp_p[k]] = 1'b0;
      step();
      s_stb_i[exp_p[k]] = 1'b1;
    end
    idle_inputs();
    step();
    m_ack_i = 1'b0;
    step();
  endtask

  task automatic test_window_miss();
    do_reset();
    req(0, 32'hFD200000, 1'b0, 0);
    req(1, 32'hFE000000, 1'b0, 0);
    for (int k = 0; k < 3; k++) begin
      step();
      n_cmp++;
      if (m_cyc_o !== 1'b0 || s_ack_o !== 4'h0) begin
        n_bad++;
        $display("FAIL miss%0d: cyc=%b ack=%b want 0 0000", k, m_cyc_o, s_ack_o);
      end
    end
    io_gate_en_i = 1'b0;
    req(2, 32'hFD000020, 1'b0, 0);
    step(); step();
    n_cmp++;
    if (m_cyc_o !== 1'b0) begin
      n_bad++;
      $display("FAIL gate_off: cyc=%b want 0", m_cyc_o);
    end
    io_gate_en_i = 1'b1;
    step();
    n_cmp++;
    if (m_cyc_o !== 1'b1 || m_adr_o !== 32'hFD000020) begin
      n_bad++;
      $display("FAIL gate_on: cyc=%b adr=%h want 1 fd000020", m_cyc_o, m_adr_o);
    end
    idle_inputs();
    step();
    n_cmp++;
    if (m_cyc_o !== 1'b0 || s_ack_o !== 4'h0) begin
      n_bad++;
      $display("FAIL abort: cyc=%b ack=%b want 0 0000", m_cyc_o, s_ack_o);
    end
  endtask

  task automatic test_timeout();
    do_reset();
    req(3, 32'hFD000010, 1'b0, 0);
    step();
    for (int k = 0; k < 7; k++) step();
    n_cmp++;
    if (s_err_o !== 4'h0 || m_cyc_o !== 1'b1) begin
      n_bad++;
      $display("FAIL tmo_early: err=%b cyc=%b want 0000 1", s_err_o, m_cyc_o);
    end
    step();
    n_cmp++;
    if (s_err_o !== 4'b1000 || m_cyc_o !== 1'b0 || s_ack_o !== 4'h0) begin
      n_bad++;
      $display("FAIL tmo_err: err=%b cyc=%b ack=%b want 1000 0 0000", s_err_o, m_cyc_o, s_ack_o);
    end
    s_stb_i[3] = 1'b0;
    #1;
    n_cmp++;
    if (s_err_o !== 4'h0) begin
      n_bad++;
      $display("FAIL tmo_err_drop: got %b want 0000", s_err_o);
    end
    idle_inputs();
    step();
  endtask

  task automatic test_posted_write();
    do_reset();
    req(0, 32'hFD000040, 1'b1, 32'h12345678);
    step();
    n_cmp++;
    if (s_ack_o !== 4'b0001) begin
      n_bad++;
      $display("FAIL post_ack: got %b want 0001", s_ack_o);
    end
    n_cmp++;
    if (m_cyc_o !== 1'b1 || m_we_o !== 1'b1 || m_dat_o !== 32'h12345678) begin
      n_bad++;
      $display("FAIL post_bus: cyc=%b we=%b dat=%h want 1 1 12345678", m_cyc_o, m_we_o, m_dat_o);
    end
    s_cyc_i[0] = 1'b0; s_stb_i[0] = 1'b0;
    req(1, 32'hFD000080, 1'b0, 0);
    step(); step(); step();
    n_cmp++;
    if (m_cyc_o !== 1'b1 || m_adr_o !== 32'hFD000040 || s_ack_o !== 4'h0) begin
      n_bad++;
      $display("FAIL post_hold: cyc=%b adr=%h ack=%b want 1 fd000040 0000", m_cyc_o, m_adr_o, s_ack_o);
    end
    m_ack_i = 1'b1;
    step();
    m_ack_i = 1'b0;
    n_cmp++;
    if (m_cyc_o !== 1'b0) begin
      n_bad++;
      $display("FAIL post_mack: cyc=%b want 0", m_cyc_o);
    end
    step();
    n_cmp++;
    if (m_cyc_o !== 1'b1 || m_adr_o !== 32'hFD000080) begin
      n_bad++;
      $display("FAIL post_next: cyc=%b adr=%h want 1 fd000080", m_cyc_o, m_adr_o);
    end
    idle_inputs();
    step();
  endtask

  task automatic test_reset_mid();
    do_reset();
    req(2, 32'hFD000100, 1'b0, 0);
    step();
    n_cmp++;
    if (m_cyc_o !== 1'b1) begin
      n_bad++;
      $display("FAIL rmid_start: cyc=%b want 1", m_cyc_o);
    end
    rst_i = 1'b1;
    step();
    n_cmp++;
    if (m_cyc_o !== 1'b0 || m_stb_o !== 1'b0 || m_adr_o !== 32'h0) begin
      n_bad++;
      $display("FAIL rmid_bus: cyc=%b stb=%b adr=%h want 0 0 0", m_cyc_o, m_stb_o, m_adr_o);
    end
    rst_i = 1'b0;
    m_ack_i = 1'b1; m_dat_i = 32'hCAFEF00D;
    step();
    n_cmp++;
    if (s_ack_o !== 4'h0 || s_err_o !== 4'h0 || s_dat_o !== 128'h0) begin
      n_bad++;
      $display("FAIL rmid_late_ack: ack=%b err=%b dat=%h want 0", s_ack_o, s_err_o, s_dat_o);
    end
    n_cmp++;
    if (m_cyc_o !== 1'b0) begin
      n_bad++;
      $display("FAIL rmid_no_grant: cyc=%b want 0", m_cyc_o);
    end
    idle_inputs();
    step();
  endtask

  initial begin
    idle_inputs();
    rst_i = 1'b1;
    test_reset();
    test_read();
    test_round_robin();
    test_window_miss();
    test_timeout();
    test_posted_write();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
